// File: rtl/sram_port0_master_if.sv
// Bundle of command, write-stream, read-stream, status and SRAM macro pins
// between the layer datapath and one OpenRAM single-port macro.
interface sram_port0_master_if #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
);
    logic                  cmd_valid;
    logic                  cmd_ready;
    logic                  cmd_write;
    logic [ADDR_WIDTH-1:0] cmd_addr;
    logic [ADDR_WIDTH-1:0] cmd_len;
    logic                  wr_valid;
    logic                  wr_ready;
    logic [DATA_WIDTH-1:0] wr_data;
    logic                  rd_valid;
    logic                  rd_ready;
    logic [DATA_WIDTH-1:0] rd_data;
    logic                  rd_last;
    logic                  busy;
    logic                  csb0;
    logic                  web0;
    logic [ADDR_WIDTH-1:0] addr0;
    logic [DATA_WIDTH-1:0] din0;
    logic [DATA_WIDTH-1:0] dout0;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, dout0,
        output cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, csb0, web0, addr0, din0
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_len, wr_valid, wr_data, rd_ready, dout0,
        input  cmd_ready, wr_ready, rd_valid, rd_data, rd_last, busy, csb0, web0, addr0, din0
    );
endinterface

// File: rtl/sram_port0_master.sv
// Turns burst commands into per-word OpenRAM port-0 accesses; write words come from a
// valid/ready stream and read words return through a 2-entry credit-managed FIFO.
module sram_port0_master #(
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 4
) (
    input logic                  clk0,
    input logic                  rst0,
    sram_port0_master_if.master  bus
);
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_WRITE = 2'd1;
    localparam logic [1:0] ST_READ  = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] base_q, base_d;
    logic [ADDR_WIDTH-1:0] len_q, len_d;
    logic [ADDR_WIDTH:0]   beat_q, beat_d;
    logic                  inflight_q;
    logic                  inflight_last_q;
    logic [DATA_WIDTH-1:0] fifo_data_q [2];
    logic                  fifo_last_q [2];
    logic                  fifo_wptr_q;
    logic                  fifo_rptr_q;
    logic [1:0]            fifo_count_q;

    logic                  cmd_fire_s;
    logic                  wr_fire_s;
    logic                  rd_issue_s;
    logic                  beat_is_last_s;
    logic [ADDR_WIDTH-1:0] beat_addr_s;
    logic                  fifo_nonempty_s;
    logic                  pop_s;
    logic [2:0]            occupancy_s;

    // Handshakes and credit check; a word leaving the FIFO this cycle frees its slot
    // in time for the capture two edges later, which keeps reads at one word per cycle.
    always_comb begin
        fifo_nonempty_s = (fifo_count_q != 2'd0);
        pop_s           = fifo_nonempty_s && bus.rd_ready;
        occupancy_s     = {1'b0, fifo_count_q} + {2'b00, inflight_q};
        cmd_fire_s      = (state_q == ST_IDLE) && bus.cmd_valid;
        wr_fire_s       = (state_q == ST_WRITE) && bus.wr_valid;
        rd_issue_s      = (state_q == ST_READ) && ((occupancy_s - {2'b00, pop_s}) < 3'd2);
        beat_is_last_s  = (beat_q == {1'b0, len_q});
        beat_addr_s     = base_q + beat_q[ADDR_WIDTH-1:0];
    end

    // Next-state logic for the burst sequencer.
    always_comb begin
        state_d = state_q;
        base_d  = base_q;
        len_d   = len_q;
        beat_d  = beat_q;
        case (state_q)
            ST_IDLE: begin
                if (cmd_fire_s) begin
                    base_d  = bus.cmd_addr;
                    len_d   = bus.cmd_len;
                    beat_d  = {(ADDR_WIDTH+1){1'b0}};
                    state_d = bus.cmd_write ? ST_WRITE : ST_READ;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WRITE: begin
                if (wr_fire_s) begin
                    beat_d  = beat_q + (ADDR_WIDTH+1)'(1);
                    state_d = beat_is_last_s ? ST_IDLE : ST_WRITE;
                end else begin
                    state_d = ST_WRITE;
                end
            end
            ST_READ: begin
                if (rd_issue_s) begin
                    beat_d  = beat_q + (ADDR_WIDTH+1)'(1);
                    state_d = beat_is_last_s ? ST_IDLE : ST_READ;
                end else begin
                    state_d = ST_READ;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // Stream, status and macro pins; the macro samples these at the edge ending the cycle.
    always_comb begin
        bus.cmd_ready = (state_q == ST_IDLE);
        bus.wr_ready  = (state_q == ST_WRITE);
        bus.rd_valid  = fifo_nonempty_s;
        bus.rd_data   = fifo_data_q[fifo_rptr_q];
        bus.rd_last   = fifo_last_q[fifo_rptr_q];
        bus.busy      = (state_q != ST_IDLE) || inflight_q || fifo_nonempty_s;
        bus.csb0      = !(wr_fire_s || rd_issue_s);
        bus.web0      = !wr_fire_s;
        if (wr_fire_s || rd_issue_s) begin
            bus.addr0 = beat_addr_s;
        end else begin
            bus.addr0 = {ADDR_WIDTH{1'b0}};
        end
        if (wr_fire_s) begin
            bus.din0 = bus.wr_data;
        end else begin
            bus.din0 = {DATA_WIDTH{1'b0}};
        end
    end

    // Sequencer state, capture pipe and FIFO pointers.
    always_ff @(posedge clk0) begin
        if (rst0) begin
            state_q         <= ST_IDLE;
            base_q          <= {ADDR_WIDTH{1'b0}};
            len_q           <= {ADDR_WIDTH{1'b0}};
            beat_q          <= {(ADDR_WIDTH+1){1'b0}};
            inflight_q      <= 1'b0;
            inflight_last_q <= 1'b0;
            fifo_wptr_q     <= 1'b0;
            fifo_rptr_q     <= 1'b0;
            fifo_count_q    <= 2'd0;
        end else begin
            state_q         <= state_d;
            base_q          <= base_d;
            len_q           <= len_d;
            beat_q          <= beat_d;
            inflight_q      <= rd_issue_s;
            inflight_last_q <= rd_issue_s && beat_is_last_s;
            if (inflight_q) begin
                fifo_wptr_q <= ~fifo_wptr_q;
            end else begin
                fifo_wptr_q <= fifo_wptr_q;
            end
            if (pop_s) begin
                fifo_rptr_q <= ~fifo_rptr_q;
            end else begin
                fifo_rptr_q <= fifo_rptr_q;
            end
            case ({inflight_q, pop_s})
                2'b10:   fifo_count_q <= fifo_count_q + 2'd1;
                2'b01:   fifo_count_q <= fifo_count_q - 2'd1;
                default: fifo_count_q <= fifo_count_q;
            endcase
        end
    end

    // dout0 is only valid at the edge ending the cycle after issue, which is when inflight_q is set.
    always_ff @(posedge clk0) begin
        if (!rst0 && inflight_q) begin
            fifo_data_q[fifo_wptr_q] <= bus.dout0;
            fifo_last_q[fifo_wptr_q] <= inflight_last_q;
        end else begin
            fifo_data_q[fifo_wptr_q] <= fifo_data_q[fifo_wptr_q];
            fifo_last_q[fifo_wptr_q] <= fifo_last_q[fifo_wptr_q];
        end
    end
endmodule
